// File: rtl/sequenciador_instrucoes_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, FSM encoding, watchdog limit.
// The watchdog limit only matters when SEQ_WATCHDOG_EN is defined.
package seq_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;

  localparam logic [7:0] WDOG_LIMIT = 8'd255;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_IMM   = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  function automatic logic [2:0] opcode_of(input logic [15:0] word);
    return word[8:6];
  endfunction

endpackage

// File: rtl/sequenciador_instrucoes_if.sv
// Sequencer bus: processor handshake (DIN/Run/Done), control/status and program load port.
// Error exists only when SEQ_WATCHDOG_EN is defined; master = sequencer, slave = environment.
interface sequenciador_instrucoes_if #(parameter int ADDR_W = 5);

  logic              Start;
  logic              Done;
  logic              Prog_we;
  logic [ADDR_W-1:0] Prog_addr;
  logic [15:0]       Prog_data;
  logic [15:0]       DIN;
  logic              Run;
  logic [ADDR_W-1:0] PC;
  logic              Busy;
  logic              Halted;
`ifdef SEQ_WATCHDOG_EN
  logic              Error;
`endif

  modport master (
    input  Start, Done, Prog_we, Prog_addr, Prog_data,
`ifdef SEQ_WATCHDOG_EN
    output Error,
`endif
    output DIN, Run, PC, Busy, Halted
  );

  modport slave (
    output Start, Done, Prog_we, Prog_addr, Prog_data,
`ifdef SEQ_WATCHDOG_EN
    input  Error,
`endif
    input  DIN, Run, PC, Busy, Halted
  );

endinterface

// File: rtl/sequenciador_instrucoes_memoria_programa.sv
// Program store: PROG_DEPTH x 16 register array, synchronous write, two asynchronous read ports
// so the current word and the following (immediate) word are visible in the same cycle.
module memoria_programa #(
  parameter int PROG_DEPTH = 32,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [15:0]       i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [15:0]       o_rdata_a,
  output logic [15:0]       o_rdata_b
);

  logic [15:0] r_mem [PROG_DEPTH];

  // Contents deliberately survive reset so a program can be rerun after a reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/sequenciador_instrucoes.sv
// Instruction feeder: issues program words to the processor over DIN/Run and waits for Done.
// SEQ_WATCHDOG_EN adds an 8-bit wait watchdog that halts the sequencer and raises Error.
module sequenciador_instrucoes
  import seq_pkg::*;
#(
  parameter int PROG_DEPTH = 32,
  parameter int ADDR_W     = 5
) (
  input  logic                       Clock,
  input  logic                       Resetn,
  sequenciador_instrucoes_if.master  bus
);

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic [ADDR_W-1:0] w_pc_plus2;
  logic [15:0]       w_word_cur;
  logic [15:0]       w_word_imm;
  logic              w_is_halt;
  logic              w_is_mvi;
  logic              w_quiet;
  logic              w_mem_we;

`ifdef SEQ_WATCHDOG_EN
  logic [7:0]        r_wdog;
  logic [7:0]        w_wdog_next;
  logic              r_error;
  logic              w_error_next;
  logic              w_wdog_expired;
`endif

  // Width-matched adds wrap modulo PROG_DEPTH, so an mvi at the last word reads address 0.
  assign w_pc_plus1 = r_pc + ADDR_W'(1);
  assign w_pc_plus2 = r_pc + ADDR_W'(2);

  assign w_quiet  = (r_state == S_IDLE) || (r_state == S_HALT);
  assign w_mem_we = bus.Prog_we && w_quiet;

  memoria_programa #(
    .PROG_DEPTH (PROG_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk       (Clock),
    .i_we      (w_mem_we),
    .i_waddr   (bus.Prog_addr),
    .i_wdata   (bus.Prog_data),
    .i_raddr_a (r_pc),
    .i_raddr_b (w_pc_plus1),
    .o_rdata_a (w_word_cur),
    .o_rdata_b (w_word_imm)
  );

  assign w_is_halt = (opcode_of(w_word_cur) == OP_HALT);
  assign w_is_mvi  = (opcode_of(w_word_cur) == OP_MVI);

`ifdef SEQ_WATCHDOG_EN
  assign w_wdog_expired = ((r_wdog + 8'd1) == WDOG_LIMIT);
`endif

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
`ifdef SEQ_WATCHDOG_EN
      r_wdog  <= '0;
      r_error <= 1'b0;
`endif
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
`ifdef SEQ_WATCHDOG_EN
      r_wdog  <= w_wdog_next;
      r_error <= w_error_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
`ifdef SEQ_WATCHDOG_EN
    w_wdog_next  = r_wdog;
    w_error_next = r_error;
`endif
    case (r_state)
      S_IDLE, S_HALT: begin
        if (bus.Start) begin
          w_state_next = S_ISSUE;
          w_pc_next    = '0;
`ifdef SEQ_WATCHDOG_EN
          w_error_next = 1'b0;
`endif
        end
      end
      S_ISSUE: begin
`ifdef SEQ_WATCHDOG_EN
        w_wdog_next = '0;
`endif
        if (w_is_halt) begin
          w_state_next = S_HALT;
        end else if (w_is_mvi) begin
          w_state_next = S_IMM;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_IMM, S_WAIT: begin
        if (bus.Done) begin
          w_state_next = S_ISSUE;
          w_pc_next    = (r_state == S_IMM) ? w_pc_plus2 : w_pc_plus1;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (w_wdog_expired) begin
          w_state_next = S_HALT;
          w_error_next = 1'b1;
        end else begin
          w_wdog_next = r_wdog + 8'd1;
        end
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decode state plus memory only; Done never reaches Run within a cycle.
  always_comb begin
    bus.DIN    = '0;
    bus.Run    = 1'b0;
    bus.Busy   = 1'b0;
    bus.Halted = 1'b0;
    case (r_state)
      S_ISSUE: begin
        bus.Busy = 1'b1;
        if (!w_is_halt) begin
          bus.DIN = w_word_cur;
          bus.Run = 1'b1;
        end
      end
      S_IMM: begin
        bus.Busy = 1'b1;
        bus.DIN  = w_word_imm;
      end
      S_WAIT: begin
        bus.Busy = 1'b1;
        bus.DIN  = w_word_cur;
      end
      S_HALT:  bus.Halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.PC = r_pc;
`ifdef SEQ_WATCHDOG_EN
  assign bus.Error = r_error;
`endif

endmodule

// File: tb/tb_sequenciador_instrucoes.sv
// Directed bench for sequenciador_instrucoes; the watchdog steps run only with SEQ_WATCHDOG_EN.
module tb_sequenciador_instrucoes;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   run_cnt;
  int   timer;

  always #5 clk = ~clk;

  sequenciador_instrucoes_if #(.ADDR_W(5)) bus ();

  sequenciador_instrucoes #(
    .PROG_DEPTH (32),
    .ADDR_W     (5)
  ) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [4:0] addr, input logic [15:0] data);
    bus.Prog_we   = 1'b1;
    bus.Prog_addr = addr;
    bus.Prog_data = data;
    tick();
    bus.Prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  initial begin
    bus.Start     = 1'b0;
    bus.Done      = 1'b0;
    bus.Prog_we   = 1'b0;
    bus.Prog_addr = '0;
    bus.Prog_data = '0;

    // Reset state
    repeat (2) tick();
    check("rst_din", bus.DIN, 32'h0);
    check("rst_run", bus.Run, 32'h0);
    check("rst_pc", bus.PC, 32'h0);
    check("rst_busy", bus.Busy, 32'h0);
    check("rst_halted", bus.Halted, 32'h0);
`ifdef SEQ_WATCHDOG_EN
    check("rst_error", bus.Error, 32'h0);
`endif
    rst_n = 1'b1;
    tick();

    // mvi R0, #5 followed by halt
    write_word(5'd0, 16'h0040);
    write_word(5'd1, 16'h0005);
    write_word(5'd2, 16'h01C0);
    pulse_start();
    check("mvi_run", bus.Run, 32'h1);
    check("mvi_din_op", bus.DIN, 32'h0040);
    tick();
    check("mvi_run_once", bus.Run, 32'h0);
    check("mvi_din_imm", bus.DIN, 32'h0005);
    repeat (3) tick();
    check("mvi_din_held", bus.DIN, 32'h0005);
    check("mvi_busy", bus.Busy, 32'h1);
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    check("mvi_pc_after", bus.PC, 32'h2);
    check("halt_no_run", bus.Run, 32'h0);
    tick();
    check("halt_flag", bus.Halted, 32'h1);
    check("halt_pc", bus.PC, 32'h2);
    check("halt_busy", bus.Busy, 32'h0);
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    check("halt_ignores_done", bus.Halted, 32'h1);

    // mv, add, halt with Done three cycles after each Run
    write_word(5'd0, 16'h0008);
    write_word(5'd1, 16'h0081);
    write_word(5'd2, 16'h01C0);
    pulse_start();
    run_cnt = 0;
    timer   = 0;
    for (int c = 0; c < 40 && !bus.Halted; c++) begin
      if (bus.Run) begin
        run_cnt++;
        timer = 3;
      end else if (timer > 0) begin
        timer--;
        if (timer == 0) bus.Done = 1'b1;
      end
      tick();
      bus.Done = 1'b0;
    end
    check("seq_run_pulses", run_cnt, 32'd2);
    check("seq_halted", bus.Halted, 32'h1);
    check("seq_pc", bus.PC, 32'h2);

    // Dropped write while busy, then asynchronous reset in WAIT
    pulse_start();
    tick();
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    tick();
    write_word(5'd1, 16'hBEEF);
    check("wait_busy", bus.Busy, 32'h1);
    check("wait_din_stable", bus.DIN, 32'h0081);
    check("wait_pc", bus.PC, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_run", bus.Run, 32'h0);
    check("arst_pc", bus.PC, 32'h0);
    check("arst_busy", bus.Busy, 32'h0);
    check("arst_din", bus.DIN, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    pulse_start();
    check("mem_kept_0", bus.DIN, 32'h0008);
    tick();
    bus.Done = 1'b1;
    tick();
    bus.Done = 1'b0;
    check("drop_we_din", bus.DIN, 32'h0081);
    check("drop_we_run", bus.Run, 32'h1);
    bus.Done = 1'b1;
    repeat (3) tick();
    bus.Done = 1'b0;
    check("rerun_halted", bus.Halted, 32'h1);

    // Done held high: one issue every two cycles, mvi at 31 wraps to 0 and 1
    write_word(5'd0, 16'h1234);
    for (int a = 1; a < 31; a++) write_word(5'(a), 16'h0008);
    write_word(5'd31, 16'h0040);
    bus.Done = 1'b1;
    pulse_start();
    for (int i = 0; i < 31; i++) begin
      check("held_run", bus.Run, 32'h1);
      check("held_pc", bus.PC, i);
      tick();
      check("held_no_double", bus.Run, 32'h0);
      tick();
    end
    check("wrap_pc31", bus.PC, 32'd31);
    check("wrap_din_op", bus.DIN, 32'h0040);
    tick();
    check("wrap_din_imm", bus.DIN, 32'h1234);
    check("wrap_imm_run", bus.Run, 32'h0);
    tick();
    check("wrap_pc1", bus.PC, 32'h1);
    check("wrap_next_run", bus.Run, 32'h1);
    check("wrap_next_din", bus.DIN, 32'h0008);
    bus.Done = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

`ifdef SEQ_WATCHDOG_EN
    // Watchdog: halt with Error exactly 255 cycles after entering WAIT
    pulse_start();
    tick();
    repeat (254) tick();
    check("wdog_not_yet", bus.Halted, 32'h0);
    check("wdog_no_error_yet", bus.Error, 32'h0);
    tick();
    check("wdog_halted", bus.Halted, 32'h1);
    check("wdog_error", bus.Error, 32'h1);
    pulse_start();
    check("wdog_error_clear", bus.Error, 32'h0);
    check("wdog_restart_run", bus.Run, 32'h1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sequenciador_instrucoes.md
# sequenciador_instrucoes

Instruction feeder for the multicycle processor: holds a small program memory, drives the processor's `DIN` and `Run` inputs, supplies the immediate word for `mvi`, waits for `Done`, and advances its program counter. It sits between the bench or top level and the processor. It is the issuing end of the processor's `DIN`/`Run`/`Done` handshake.

## Interface
- `PROG_DEPTH`, default 32: program words; must be a power of two.
- `ADDR_W`, default 5: log2(`PROG_DEPTH`).
- `Clock`  in  1: single clock; all state changes on the rising edge.
- `Resetn`  in  1: asynchronous, active-low reset.
- `Start`  in  1: one-cycle pulse; starts execution at address 0 from IDLE or HALT.
- `Done`  in  1: processor completion, sampled on the rising edge.
- `Prog_we`  in  1: program write enable; honoured only in IDLE or HALT.
- `Prog_addr`  in  `ADDR_W`: program write address.
- `Prog_data`  in  16: program write data.
- `DIN`  out  16: word presented to the processor.
- `Run`  out  1: instruction-issue strobe to the processor.
- `PC`  out  `ADDR_W`: address of the current instruction.
- `Busy`  out  1: high in ISSUE, IMM and WAIT.
- `Halted`  out  1: high in HALT.
- `Error`  out  1: watchdog fault, sticky until `Start` or reset. Present only with the macro in Configuration.

## Operation
- Instruction word format: `DIN[8:6]` = opcode, `[5:3]` = X, `[2:0]` = Y. Opcodes: 000 mv, 001 mvi, 010 add, 011 sub, 111 halt. Other opcodes are issued as-is.
- Program memory is read asynchronously: `mem[PC]` and `mem[PC+1]` are visible in the same cycle.
- Address arithmetic is modulo `PROG_DEPTH`. An `mvi` at the last address takes its immediate from address 0.
- FSM states:
  - IDLE: outputs quiet. `Start` sets PC=0 and moves to ISSUE.
  - ISSUE: if `mem[PC][8:6]`=111, move to HALT without asserting `Run`. Otherwise `DIN=mem[PC]`, `Run=1` for exactly this cycle. Next state is IMM if the opcode is 001, else WAIT.
  - IMM: `DIN=mem[PC+1]`, held until `Done` is sampled. On `Done`: PC+=2, go to ISSUE.
  - WAIT: `DIN=mem[PC]`, held. On `Done`: PC+=1, go to ISSUE.
  - HALT: `Halted=1`, PC frozen. `Start` sets PC=0 and moves to ISSUE.
- `Done` is ignored in IDLE, ISSUE and HALT.
- `Start` is ignored while `Busy`=1.
- `Prog_we` while `Busy`=1 is dropped, and memory is unchanged.
- Reset mid-instruction: all outputs return to reset values immediately. Program memory contents are not reset.

## Timing
- Reset values: `DIN`=0, `Run`=0, `PC`=0, `Busy`=0, `Halted`=0, `Error`=0; state IDLE.
- `Start` sampled in edge n → `Run`=1 during cycle n+1.
- `Done` sampled in edge m → next `Run` during cycle m+1.
  - Minimum gap: one idle cycle between instructions (WAIT/IMM → ISSUE).
- All outputs are registered or decoded from the state plus the memory. There is no combinational path from `Done` to `Run`.
- `DIN` changes only on a state or PC change and is stable while waiting for `Done`.
- A program write at edge k is visible to a read from cycle k+1.

## Configuration
- `SEQ_WATCHDOG_EN` defined: an 8-bit counter runs in IMM and WAIT and clears on each entry to ISSUE.
  - If it reaches 255 without `Done`, the FSM moves to HALT and sets `Error`=1.
  - The `Error` port exists.
- `SEQ_WATCHDOG_EN` not defined: no counter and no `Error` port. The FSM waits for `Done` indefinitely.

## Structure
- Package `seq_pkg`: opcode constants (`OP_MV`, `OP_MVI`, `OP_ADD`, `OP_SUB`, `OP_HALT`), the state encoding, and the watchdog limit constant.
- Sub-module `memoria_programa`: `PROG_DEPTH`×16 register array, synchronous write, two asynchronous read ports.

## Test plan
- Reset, then `Start` with `mem[0]`=0x0040 (mvi R0) and `mem[1]`=0x0005:
  - `Run`=1 for one cycle with `DIN`=0x0040.
  - Next cycle `DIN`=0x0005, held until `Done`.
  - After `Done`, PC=2.
- Sequence mv(0x0008), add(0x0081), halt(0x01C0), with `Done` pulsed 3 cycles after each `Run`:
  - Exactly 2 `Run` pulses.
  - `Halted`=1 with PC=2.
- `mvi` at address 31 with `mem[0]`=0x1234 → `DIN`=0x1234 in IMM; PC wraps to 1.
- `Done` held high throughout → one instruction per 2 cycles; `Done` never triggers a double issue.
- `Resetn` low during WAIT → `Run`=0, `PC`=0, `Busy`=0 asynchronously. A `Prog_we` during `Busy` leaves memory unchanged.
- With `SEQ_WATCHDOG_EN`, withhold `Done` → HALT and `Error`=1 exactly 255 cycles after entering WAIT. `Start` clears `Error`.
